// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - physical-register free-list allocator with lowest-index staging
module preg_free_list #(
  parameter int NUM_PREGS    = 64,
  parameter int NUM_RESERVED = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           alloc_valid,
  output logic [$clog2(NUM_PREGS)-1:0]   alloc_preg,
  input  logic                           alloc_req,
  input  logic                           free_valid,
  input  logic [$clog2(NUM_PREGS)-1:0]   free_preg,
  input  logic                           flush_valid,
  input  logic [NUM_PREGS-1:0]           flush_free_mask,
  output logic [$clog2(NUM_PREGS+1)-1:0] free_count,
  output logic                           double_free
);

  localparam int IW = $clog2(NUM_PREGS);
  localparam int CW = $clog2(NUM_PREGS + 1);

  // Architectural registers start mapped; register 0 is never free.
  function automatic logic [NUM_PREGS-1:0] build_reset_mask();
    logic [NUM_PREGS-1:0] m;
    m = '0;
    for (int i = 1; i < NUM_PREGS; i++) begin
      if (i >= NUM_RESERVED) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NUM_PREGS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  localparam logic [NUM_PREGS-1:0] RESET_MASK  = build_reset_mask();
  localparam logic [CW-1:0]        RESET_COUNT = popcount(RESET_MASK);
  localparam logic [NUM_PREGS-1:0] KEEP_MASK   = {{(NUM_PREGS-1){1'b1}}, 1'b0};

  logic [NUM_PREGS-1:0] free_mask_q, free_mask_d;
  logic                 alloc_valid_q, alloc_valid_d;
  logic [IW-1:0]        alloc_preg_q, alloc_preg_d;
  logic [CW-1:0]        free_count_q, free_count_d;
  logic                 double_free_q, double_free_d;

  logic                 fire;
  logic                 free_nonzero;
  logic                 dbl_hit;
  logic                 free_ok;
  logic                 load_slot;
  logic                 load_ok;
  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic [NUM_PREGS-1:0] sel_onehot;
  logic [NUM_PREGS-1:0] free_onehot;
  logic [NUM_PREGS-1:0] flush_mask_eff;
  logic [CW-1:0]        flush_count;

  assign fire         = alloc_valid_q & alloc_req;
  assign free_nonzero = free_valid & (free_preg != '0);
  // A release is bogus if the register is already free or is the one sitting in the staging slot.
  assign dbl_hit      = free_nonzero &
                        (free_mask_q[free_preg] | (alloc_valid_q & (alloc_preg_q == free_preg)));
  assign free_ok      = free_nonzero & ~dbl_hit;
  assign load_slot    = (~alloc_valid_q | fire) & ~flush_valid;
  assign load_ok      = load_slot & sel_found;

  // Lowest-index priority encoder over the registered free mask.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_PREGS - 1; i >= 0; i--) begin
      if (free_mask_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // One-hot masks for the bit being taken by the stage and the bit being released.
  always_comb begin
    sel_onehot  = '0;
    free_onehot = '0;
    if (load_ok) sel_onehot[sel_idx] = 1'b1;
    if (free_ok) free_onehot[free_preg] = 1'b1;
  end

  // Checkpoint restore image, with the same-cycle release merged in.
  always_comb begin
    flush_mask_eff = (flush_free_mask | free_onehot) & KEEP_MASK;
    flush_count    = popcount(flush_mask_eff);
  end

  // Next-state for bitmap, staging slot, count and error flag.
  always_comb begin
    free_mask_d   = free_mask_q;
    alloc_valid_d = alloc_valid_q;
    alloc_preg_d  = alloc_preg_q;
    free_count_d  = free_count_q;
    double_free_d = double_free_q | dbl_hit;
    if (flush_valid) begin
      free_mask_d   = flush_mask_eff;
      free_count_d  = flush_count;
      alloc_valid_d = 1'b0;
    end else begin
      // Selected bit is cleared before the released bit is merged in.
      free_mask_d  = ((free_mask_q & ~sel_onehot) | free_onehot) & KEEP_MASK;
      free_count_d = free_count_q + CW'(free_ok) - CW'(load_ok);
      if (load_slot) begin
        alloc_valid_d = sel_found;
        if (sel_found) alloc_preg_d = sel_idx;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_mask_q   <= RESET_MASK;
      alloc_valid_q <= 1'b0;
      alloc_preg_q  <= '0;
      free_count_q  <= RESET_COUNT;
      double_free_q <= 1'b0;
    end else begin
      free_mask_q   <= free_mask_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_preg_q  <= alloc_preg_d;
      free_count_q  <= free_count_d;
      double_free_q <= double_free_d;
    end
  end

  assign alloc_valid = alloc_valid_q;
  assign alloc_preg  = alloc_preg_q;
  assign free_count  = free_count_q;
  assign double_free = double_free_q;

endmodule
